// File: rtl/pam_pkg.sv
// Shared definitions for the PAM serial link receive path.
package pam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_WRITE    = 2'd2,
    ST_WAITSYNC = 2'd3
  } pam_state_t;

  localparam int DEF_DATA_LENGTH = 24;
  localparam int DEF_BYTES_OUT   = 2;
  localparam int DEF_BCLK_PERIOD = 12;

endpackage

// File: rtl/pam_demodulator_if.sv
// FIFO write-side bundle between the PAM demodulator (master) and the sample FIFO (slave).
interface pam_demodulator_if;
  logic [7:0] data;
  logic       write;
  logic       full;

  modport master (output data, output write, input full);
  modport slave  (input data, input write, output full);
endinterface

// File: rtl/pam_sync_edge.sv
// N-stage synchronizer for one line pin, with an optional 1->0 edge pulse.
module pam_sync_edge #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic fall
);

  // Flops preset high so an idle (high) line looks idle straight out of reset
  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_p <= '1;
    else      sync_p <= {sync_p[STAGES-2:0], d};
  end

  assign q = sync_p[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic q_p;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_p <= 1'b1;
        else      q_p <= q;
      end
      assign fall = q_p & ~q;
    end else begin : g_no_edge
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pam_demodulator.sv
// PAM link receiver: oversamples nsync/bclk/sdata, rebuilds MSB-first frames, writes payload bytes low first.
// Optional bclk gap timeout enabled by defining PAM_RX_TIMEOUT_EN.
module pam_demodulator
  import pam_pkg::*;
#(
  parameter int DATA_LENGTH  = DEF_DATA_LENGTH,
  parameter int BYTES_OUT    = DEF_BYTES_OUT,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_CLKS = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   nsync,
  input  logic                   bclk,
  input  logic                   sdata,
  pam_demodulator_if.master      fifo,
  output logic [DATA_LENGTH-1:0] word,
  output logic                   word_valid,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int CNT_W = $clog2(DATA_LENGTH);
  localparam int IDX_W = $clog2(BYTES_OUT) + 1;
  localparam int FL_W  = $clog2(SYNC_STAGES + 1);

  logic nsync_s, sdata_s, bclk_s, bclk_fall;
  logic nsync_fall_unused, sdata_fall_unused;

  pam_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_bclk (
    .clk(clk), .rst(rst), .d(bclk), .q(bclk_s), .fall(bclk_fall));
  pam_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_nsync (
    .clk(clk), .rst(rst), .d(nsync), .q(nsync_s), .fall(nsync_fall_unused));
  pam_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sdata (
    .clk(clk), .rst(rst), .d(sdata), .q(sdata_s), .fall(sdata_fall_unused));

  pam_state_t             state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_LENGTH-1:0] shift_reg;
  logic [IDX_W-1:0]       idx;
  logic                   load_p;
  logic                   armed;
  logic [FL_W-1:0]        flush_cnt;
  logic [7:0]             cur_byte;

`ifdef PAM_RX_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CLKS);
  logic [GAP_W-1:0] gap_cnt;
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT_CLKS;
`endif

  always_comb begin
    cur_byte = '0;
    for (int b = 0; b < BYTES_OUT; b++)
      if (idx == b[IDX_W-1:0]) cur_byte = word[8*b +: 8];
  end

  // Arming waits until the preset synchronizer has flushed, so a line already low at reset is ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      idx        <= '0;
      load_p     <= 1'b0;
      armed      <= 1'b0;
      flush_cnt  <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      fifo.write <= 1'b0;
      fifo.data  <= '0;
`ifdef PAM_RX_TIMEOUT_EN
      gap_cnt    <= '0;
`endif
    end else begin
      word_valid <= 1'b0;
      fifo.write <= 1'b0;
      if (flush_cnt != FL_W'(SYNC_STAGES)) flush_cnt <= flush_cnt + 1'b1;
      else if (nsync_s)                    armed     <= 1'b1;

      if (enable) begin
        case (state)
          ST_IDLE: begin
            if (armed && !nsync_s) begin
              bit_cnt <= '0;
`ifdef PAM_RX_TIMEOUT_EN
              gap_cnt <= '0;
`endif
              state   <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (bclk_fall) begin
              shift_reg <= {shift_reg[DATA_LENGTH-2:0], sdata_s};
`ifdef PAM_RX_TIMEOUT_EN
              gap_cnt   <= '0;
`endif
              if (bit_cnt == CNT_W'(DATA_LENGTH - 1)) begin
                load_p <= 1'b1;
                state  <= ST_WRITE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (nsync_s) begin
              frame_err <= 1'b1;
              shift_reg <= '0;
              state     <= ST_IDLE;
            end
`ifdef PAM_RX_TIMEOUT_EN
            else if (gap_cnt == GAP_W'(TIMEOUT_CLKS - 1)) begin
              frame_err <= 1'b1;
              shift_reg <= '0;
              state     <= ST_WAITSYNC;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
`endif
          end
          ST_WRITE: begin
            if (load_p) begin
              word       <= shift_reg;
              word_valid <= 1'b1;
              idx        <= '0;
              load_p     <= 1'b0;
            end else if (fifo.full) begin
              // Whole frame is dropped only if nothing of it has gone out yet
              if (idx == '0) begin
                overrun <= 1'b1;
                state   <= ST_WAITSYNC;
              end
            end else begin
              fifo.write <= 1'b1;
              fifo.data  <= cur_byte;
              idx        <= idx + 1'b1;
              if (idx == IDX_W'(BYTES_OUT - 1)) state <= ST_WAITSYNC;
            end
          end
          ST_WAITSYNC: begin
            if (nsync_s) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/pam_demodulator.md
Name: pam_demodulator

Overview:
- Receive end of the PAM serial link: accepts the nsync/bclk/sdata stream produced by the PAM modulator and reassembles each MSB-first frame into a word.
- Pushes the payload bytes into a downstream FIFO, low byte first; two bytes per frame by default.
- Sits between the external serial pins and the sample FIFO. Runs in the fast system clock domain (120 MHz); bclk is oversampled, not used as a clock.

Parameters:
- PARAMETER01, 24: DATA_LENGTH, bits per frame (nsync-low window).
- PARAMETER02, 2: BYTES_OUT, payload bytes written to the FIFO per frame (taken from word[8*BYTES_OUT-1:0]).
- PARAMETER03, 2: SYNC_STAGES, synchronizer flops on nsync/bclk/sdata (>=2).
- PARAMETER04, 64: TIMEOUT_CLKS, max clocks between bclk falling edges inside a frame (used only with PAM_RX_TIMEOUT_EN).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low.
- enable, input, 1: when 0, state is held and no FIFO writes occur; synchronizers keep running.
- nsync, input, 1: frame strobe from the line, low during a frame.
- bclk, input, 1: bit clock from the line.
- sdata, input, 1: serial data from the line.
- data, output, 8: FIFO write data.
- write, output, 1: FIFO write strobe, one clk per byte.
- full, input, 1: FIFO full.
- word, output, DATA_LENGTH: last complete frame.
- word_valid, output, 1: one-clk pulse when word updates.
- frame_err, output, 1: sticky; set on an aborted frame; cleared only by reset.
- overrun, output, 1: sticky; set when a frame is dropped because full=1; cleared only by reset.

Behaviour:
- Reset (rst=0, async): all outputs 0, shift register 0, counters 0, state ST_IDLE; synchronizer flops preset to 1 (nsync idle high).
- Edge detect: the registered synchronized bclk gives a fall pulse on a 1->0 transition. Data is sampled on bclk fall; the transmitter changes sdata on bclk rise.
- States:
  - ST_IDLE: on synchronized nsync=0, clear bit counter -> ST_SHIFT.
  - ST_SHIFT: on each fall while nsync=0, shift_reg <= {shift_reg, sdata_s} and increment the bit counter. When the counter reaches DATA_LENGTH-1 on a fall: next cycle load word, pulse word_valid, byte index 0 -> ST_WRITE.
  - Abort: nsync rising before DATA_LENGTH bits are received sets frame_err, discards the partial word, no writes -> ST_IDLE.
  - ST_WRITE: on each cycle with full=0, write=1 and data=word[8*idx+7:8*idx], then idx++. After BYTES_OUT writes -> ST_WAITSYNC.
  - full=1 at byte index 0: drop the whole frame, set overrun, no writes -> ST_WAITSYNC.
  - full=1 mid-frame: stall; write=0 and data held until full=0. Partial frames are never dropped.
  - ST_WAITSYNC: wait for synchronized nsync=1 -> ST_IDLE. Guarantees one frame per nsync window.
- Extra falls after DATA_LENGTH bits within the same nsync-low window are ignored.
- Latency: pin fall to word_valid = SYNC_STAGES+2 clk. word_valid to first write = 1 clk when full=0.
- Bit counter width: $clog2(DATA_LENGTH). Byte index width: $clog2(BYTES_OUT)+1.
- Async reset mid-frame: immediate return to ST_IDLE, no write, frame lost. After reset, an nsync already low is ignored until it has been seen high once.

Optional Feature:
- Macro PAM_RX_TIMEOUT_EN.
- With the macro: a gap counter in ST_SHIFT is cleared on every fall. Reaching TIMEOUT_CLKS-1 sets frame_err, discards the frame -> ST_WAITSYNC.
- Without the macro: no gap counter, no timeout; PARAMETER04 is unused.

Decomposition:
- Shared package pam_pkg: state encodings (ST_IDLE, ST_SHIFT, ST_WRITE, ST_WAITSYNC), default DATA_LENGTH=24, default BYTES_OUT=2, default bclk period (12 clk).
- Sub-module pam_sync_edge: parameterized N-stage synchronizer plus fall detector, instanced for bclk. The same synchronizer is used without edge output for nsync and sdata.

Test Plan:
- Reset: rst=0 mid-stream -> all outputs 0 within the same clk; no write until nsync is seen high then low.
- Nominal: modulator-format frame 0x00A55A, bclk period 12 clk, full=0 -> word=0x00A55A, word_valid one pulse, writes 0x5A then 0xA5 on consecutive clks.
- Short frame: nsync deasserted after 10 bits -> frame_err=1, no write, next good frame 0x001234 writes 0x34, 0x12.
- Full: full=1 at word_valid -> no writes, overrun=1. full toggled 1 for 3 clk between byte0 and byte1 -> byte1 delayed 3 clk, value intact.
- Back-to-back frames 0x000001, 0x0000FF with a 1-bclk nsync-high gap -> writes 01,00,FF,00, no errors.
- PAM_RX_TIMEOUT_EN, TIMEOUT_CLKS=64: bclk stopped for 100 clk mid-frame -> frame_err=1 at gap clk 63, no write. Without the macro: no frame_err.
